// File: rtl/blit_cmd_arbiter.sv
// rtl/blit_cmd_arbiter.sv - packet-granular round-robin arbiter onto the blit command FIFO write port
module blit_cmd_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int MARGIN       = 4,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ*128-1:0] i_req_cmd,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [127:0]           o_fifo_cmd,
    output logic                   o_fifo_cmd_valid,
    input  logic [7:0]             i_fifo_slots_free,
    input  logic                   i_fifo_overflow,
    output logic [1:0]             o_grant_id,
    output logic                   o_busy,
    output logic [1:0]             o_error
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t       r_state;
    logic [1:0]   r_rr_ptr;
    logic [1:0]   r_owner;
    logic [7:0]   r_idle_cnt;
    logic [127:0] r_fifo_cmd;
    logic         r_fifo_cmd_valid;
    logic [1:0]   r_grant_id;
    logic [1:0]   r_error;

    logic         w_credit_ok;
    logic         w_any;
    logic [1:0]   w_winner;
    logic [1:0]   w_sel;
    logic         w_sel_valid;
    logic         w_sel_last;
    logic [127:0] w_sel_cmd;
    logic         w_accept;

    // Winner: first valid requester after the last packet's granted index.
    always_comb begin
        w_credit_ok = (i_fifo_slots_free >= 8'(MARGIN));
        w_any       = 1'b0;
        w_winner    = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_any && (j == (int'(r_rr_ptr) + k) % NUM_REQ) && i_req_valid[j]) begin
                    w_any    = 1'b1;
                    w_winner = 2'(j);
                end
            end
        end
    end

    // While locked only the owner is considered; outsiders never see ready.
    always_comb begin
        w_sel       = (r_state == S_LOCKED) ? r_owner : w_winner;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_cmd   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j == int'(w_sel)) begin
                w_sel_valid = i_req_valid[j];
                w_sel_last  = i_req_last[j];
                w_sel_cmd   = i_req_cmd[j*128 +: 128];
            end
        end
        w_accept    = !reset && w_credit_ok && w_sel_valid;
        o_req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            o_req_ready[j] = w_accept && (j == int'(w_sel));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_rr_ptr         <= 2'(NUM_REQ - 1);
            r_owner          <= 2'd0;
            r_idle_cnt       <= 8'd0;
            r_fifo_cmd       <= '0;
            r_fifo_cmd_valid <= 1'b0;
            r_grant_id       <= 2'd0;
            r_error          <= 2'b00;
        end else begin
            r_fifo_cmd_valid <= w_accept;
            if (i_fifo_overflow) r_error[1] <= 1'b1;
            if (w_accept) begin
                r_fifo_cmd <= w_sel_cmd;
                r_grant_id <= w_sel;
            end
            case (r_state)
                S_IDLE: begin
                    r_idle_cnt <= 8'd0;
                    if (w_accept) begin
                        if (w_sel_last) begin
                            r_rr_ptr <= w_winner;
                        end else begin
                            r_state <= S_LOCKED;
                            r_owner <= w_winner;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_accept && w_sel_last) begin
                        r_state    <= S_IDLE;
                        r_rr_ptr   <= r_owner;
                        r_idle_cnt <= 8'd0;
                    end else if (w_sel_valid) begin
                        r_idle_cnt <= 8'd0;
                    end else if (w_credit_ok) begin
                        // Back-pressure from the FIFO is not the owner's fault, so only count with credit.
                        if (r_idle_cnt == 8'(LOCK_TIMEOUT - 1)) begin
                            r_state    <= S_IDLE;
                            r_rr_ptr   <= r_owner;
                            r_idle_cnt <= 8'd0;
                            r_error[0] <= 1'b1;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fifo_cmd       = r_fifo_cmd;
    assign o_fifo_cmd_valid = r_fifo_cmd_valid;
    assign o_grant_id       = r_grant_id;
    assign o_busy           = (r_state == S_LOCKED);
    assign o_error          = r_error;

endmodule

// File: tb/tb_blit_cmd_arbiter.sv
// tb/tb_blit_cmd_arbiter.sv - directed vector bench for blit_cmd_arbiter
module tb_blit_cmd_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [255:0] i_req_cmd;
    logic [1:0]   i_req_valid;
    logic [1:0]   i_req_last;
    logic [1:0]   o_req_ready;
    logic [127:0] o_fifo_cmd;
    logic         o_fifo_cmd_valid;
    logic [7:0]   i_fifo_slots_free;
    logic         i_fifo_overflow;
    logic [1:0]   o_grant_id;
    logic         o_busy;
    logic [1:0]   o_error;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    blit_cmd_arbiter #(.NUM_REQ(2), .MARGIN(4), .LOCK_TIMEOUT(255)) dut (
        .clock            (clock),
        .reset            (reset),
        .i_req_cmd        (i_req_cmd),
        .i_req_valid      (i_req_valid),
        .i_req_last       (i_req_last),
        .o_req_ready      (o_req_ready),
        .o_fifo_cmd       (o_fifo_cmd),
        .o_fifo_cmd_valid (o_fifo_cmd_valid),
        .i_fifo_slots_free(i_fifo_slots_free),
        .i_fifo_overflow  (i_fifo_overflow),
        .o_grant_id       (o_grant_id),
        .o_busy           (o_busy),
        .o_error          (o_error)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  last;
        logic [31:0] c0;
        logic [31:0] c1;
        logic [7:0]  slots;
        logic [1:0]  rdy;
        logic        fv;
        logic [31:0] fcmd;
        logic [1:0]  gid;
        logic        busy;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [31:0] c0,
                         input logic [31:0] c1, input logic [7:0] s);
        i_req_valid       = v;
        i_req_last        = l;
        i_req_cmd         = {96'd0, c1, 96'd0, c0};
        i_fifo_slots_free = s;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // {valid, last, cmd0, cmd1, slots, ready, next valid, next cmd, next grant, next busy}
        vecs[0]  = '{2'b01, 2'b01, 32'hA,  32'h0,  8'd255, 2'b01, 1'b1, 32'hA,  2'd0, 1'b0};
        vecs[1]  = '{2'b00, 2'b00, 32'h0,  32'h0,  8'd255, 2'b00, 1'b0, 32'hA,  2'd0, 1'b0};
        vecs[2]  = '{2'b11, 2'b11, 32'h10, 32'h11, 8'd255, 2'b10, 1'b1, 32'h11, 2'd1, 1'b0};
        vecs[3]  = '{2'b11, 2'b11, 32'h20, 32'h21, 8'd255, 2'b01, 1'b1, 32'h20, 2'd0, 1'b0};
        vecs[4]  = '{2'b11, 2'b11, 32'h30, 32'h31, 8'd255, 2'b10, 1'b1, 32'h31, 2'd1, 1'b0};
        vecs[5]  = '{2'b11, 2'b11, 32'h40, 32'h41, 8'd255, 2'b01, 1'b1, 32'h40, 2'd0, 1'b0};
        vecs[6]  = '{2'b11, 2'b01, 32'h50, 32'h61, 8'd255, 2'b10, 1'b1, 32'h61, 2'd1, 1'b1};
        vecs[7]  = '{2'b11, 2'b01, 32'h50, 32'h62, 8'd255, 2'b10, 1'b1, 32'h62, 2'd1, 1'b1};
        vecs[8]  = '{2'b11, 2'b11, 32'h50, 32'h63, 8'd255, 2'b10, 1'b1, 32'h63, 2'd1, 1'b0};
        vecs[9]  = '{2'b01, 2'b01, 32'h50, 32'h0,  8'd255, 2'b01, 1'b1, 32'h50, 2'd0, 1'b0};
        vecs[10] = '{2'b01, 2'b01, 32'h70, 32'h0,  8'd3,   2'b00, 1'b0, 32'h50, 2'd0, 1'b0};
        vecs[11] = '{2'b01, 2'b01, 32'h70, 32'h0,  8'd3,   2'b00, 1'b0, 32'h50, 2'd0, 1'b0};
        vecs[12] = '{2'b01, 2'b01, 32'h70, 32'h0,  8'd4,   2'b01, 1'b1, 32'h70, 2'd0, 1'b0};
        vecs[13] = '{2'b01, 2'b00, 32'h80, 32'h0,  8'd255, 2'b01, 1'b1, 32'h80, 2'd0, 1'b1};
        vecs[14] = '{2'b11, 2'b11, 32'h81, 32'h90, 8'd2,   2'b00, 1'b0, 32'h80, 2'd0, 1'b1};
        vecs[15] = '{2'b11, 2'b11, 32'h81, 32'h90, 8'd255, 2'b01, 1'b1, 32'h81, 2'd0, 1'b0};
        vecs[16] = '{2'b10, 2'b10, 32'h0,  32'h90, 8'd255, 2'b10, 1'b1, 32'h90, 2'd1, 1'b0};

        reset = 1'b1;
        i_fifo_overflow = 1'b0;
        drive(2'b11, 2'b11, 32'h1, 32'h2, 8'd255);
        @(negedge clock);
        chk("ready_in_reset", 128'(o_req_ready), 128'(2'b00));
        step();
        step();
        chk("rst_fvalid", 128'(o_fifo_cmd_valid), 128'(1'b0));
        chk("rst_fcmd", o_fifo_cmd, 128'd0);
        chk("rst_grant", 128'(o_grant_id), 128'(2'd0));
        chk("rst_busy", 128'(o_busy), 128'(1'b0));
        chk("rst_error", 128'(o_error), 128'(2'b00));
        reset = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 8'd255);
        step();

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].valid, vecs[i].last, vecs[i].c0, vecs[i].c1, vecs[i].slots);
            @(negedge clock);
            chk($sformatf("v%0d_ready", i), 128'(o_req_ready), 128'(vecs[i].rdy));
            step();
            chk($sformatf("v%0d_fvalid", i), 128'(o_fifo_cmd_valid), 128'(vecs[i].fv));
            chk($sformatf("v%0d_fcmd", i), o_fifo_cmd, 128'(vecs[i].fcmd));
            chk($sformatf("v%0d_grant", i), 128'(o_grant_id), 128'(vecs[i].gid));
            chk($sformatf("v%0d_busy", i), 128'(o_busy), 128'(vecs[i].busy));
        end

        // Lock timeout: req0 opens a packet then goes silent while req1 waits.
        drive(2'b01, 2'b00, 32'hB0, 32'h0, 8'd255);
        @(negedge clock);
        chk("to_start_ready", 128'(o_req_ready), 128'(2'b01));
        step();
        drive(2'b10, 2'b10, 32'h0, 32'hC1, 8'd255);
        for (int n = 0; n < 254; n++) begin
            @(negedge clock);
            if (n == 100) chk("to_holdoff_ready", 128'(o_req_ready), 128'(2'b00));
            step();
        end
        chk("to_busy_254", 128'(o_busy), 128'(1'b1));
        chk("to_err_254", 128'(o_error), 128'(2'b00));
        step();
        chk("to_busy_255", 128'(o_busy), 128'(1'b0));
        chk("to_err_255", 128'(o_error), 128'(2'b01));
        @(negedge clock);
        chk("to_req1_ready", 128'(o_req_ready), 128'(2'b10));
        step();
        chk("to_req1_fcmd", o_fifo_cmd, 128'(32'hC1));
        chk("to_req1_grant", 128'(o_grant_id), 128'(2'd1));

        // Overflow is sticky.
        drive(2'b00, 2'b00, 32'h0, 32'h0, 8'd255);
        i_fifo_overflow = 1'b1;
        step();
        i_fifo_overflow = 1'b0;
        chk("ovf_set", 128'(o_error), 128'(2'b11));
        step();
        step();
        chk("ovf_sticky", 128'(o_error), 128'(2'b11));

        // Reset mid-packet with req1 owning the lock.
        drive(2'b10, 2'b00, 32'h0, 32'hD1, 8'd255);
        step();
        chk("mid_busy", 128'(o_busy), 128'(1'b1));
        chk("mid_grant", 128'(o_grant_id), 128'(2'd1));
        reset = 1'b1;
        drive(2'b11, 2'b11, 32'hE0, 32'hE1, 8'd255);
        @(negedge clock);
        chk("mid_rst_ready", 128'(o_req_ready), 128'(2'b00));
        step();
        chk("mid_rst_busy", 128'(o_busy), 128'(1'b0));
        chk("mid_rst_fvalid", 128'(o_fifo_cmd_valid), 128'(1'b0));
        chk("mid_rst_error", 128'(o_error), 128'(2'b00));
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", 128'(o_req_ready), 128'(2'b01));
        step();
        chk("post_rst_fcmd", o_fifo_cmd, 128'(32'hE0));
        chk("post_rst_grant", 128'(o_grant_id), 128'(2'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
